// File: rtl/tdm_pkg.sv
// tdm_pkg: shared types and constants for the TDM demultiplexer.
//   state_t  : sync FSM states (HUNT, LOCKED)
//   ctl_t    : per-cycle control from the sync FSM to the datapath
//   ERR_W    : width of the saturating sync-error counter
//   DEF_*    : default slot count and miss limit
package tdm_pkg;
  typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} state_t;

  localparam int ERR_W          = 8;
  localparam int SLOT_W         = 4;   // covers up to 16 slots
  localparam int MISS_W         = 4;   // covers a miss limit up to 15
  localparam int DEF_NUM_CH     = 2;
  localparam int DEF_MISS_LIMIT = 3;

  typedef struct packed {
    logic              cap;       // sample serial_in this cycle
    logic [SLOT_W-1:0] idx;       // shadow slot to write
    logic              complete;  // last slot of a good frame
    logic              realign;   // misaligned sync, restart frame
  } ctl_t;
endpackage

// File: rtl/tdm_sync_fsm.sv
// tdm_sync_fsm: frame alignment FSM with slot counter and miss counter.
//   clk, rst_n  : clock, async active-low reset
//   frame_sync  : slot-0 marker from the line
//   ctl         : sample/complete/realign strobes for the datapath
//   locked      : state == LOCKED, driven straight from the state flop
module tdm_sync_fsm import tdm_pkg::*; #(
  parameter int NUM_CH     = DEF_NUM_CH,
  parameter int MISS_LIMIT = DEF_MISS_LIMIT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic frame_sync,
  output ctl_t ctl,
  output logic locked
);
  localparam logic [SLOT_W-1:0] LAST = SLOT_W'(NUM_CH - 1);

  state_t            state_q, state_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [MISS_W-1:0] miss_q, miss_d, miss_inc;

  assign miss_inc = miss_q + 1'b1;
  assign locked   = (state_q == LOCKED);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= HUNT;
      slot_q  <= '0;
      miss_q  <= '0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      miss_q  <= miss_d;
    end
  end

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    miss_d  = miss_q;
    ctl     = '0;
    case (state_q)
      HUNT: begin
        if (frame_sync) begin
          state_d = LOCKED;
          slot_d  = SLOT_W'(1);
          miss_d  = '0;
          ctl.cap = 1'b1;
        end
      end
      LOCKED: begin
        if (slot_q == '0) begin
          // Frame boundary: a missing sync is tolerated (flywheel) until
          // the limit is hit, then the partial frame is abandoned.
          if (!frame_sync && (miss_inc >= MISS_W'(MISS_LIMIT))) begin
            state_d = HUNT;
            slot_d  = '0;
            miss_d  = '0;
          end else begin
            miss_d  = frame_sync ? '0 : miss_inc;
            ctl.cap = 1'b1;
            slot_d  = SLOT_W'(1);
          end
        end else if (frame_sync) begin
          // Sync in the wrong slot wins over frame completion: restart
          // the frame with this bit as slot 0.
          ctl.realign = 1'b1;
          ctl.cap     = 1'b1;
          slot_d      = SLOT_W'(1);
          miss_d      = '0;
        end else begin
          ctl.cap = 1'b1;
          ctl.idx = slot_q;
          if (slot_q == LAST) begin
            ctl.complete = 1'b1;
            slot_d       = '0;
          end else begin
            slot_d = slot_q + 1'b1;
          end
        end
      end
      default: state_d = HUNT;
    endcase
  end
endmodule

// File: rtl/tdm_demux.sv
// tdm_demux: serial TDM line to parallel channel bits.
//   clk, rst_n  : clock, async active-low reset
//   serial_in   : one slot bit per cycle
//   frame_sync  : high with the slot-0 bit
//   ch_out      : slot k of the last complete frame on bit k
//   frame_valid : one-cycle pulse when ch_out updates
//   locked      : FSM in LOCKED
//   sync_err    : one-cycle pulse on a misaligned sync
//   err_cnt     : saturating count of sync_err events
module tdm_demux import tdm_pkg::*; #(
  parameter int NUM_CH     = DEF_NUM_CH,
  parameter int MISS_LIMIT = DEF_MISS_LIMIT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              serial_in,
  input  logic              frame_sync,
  output logic [NUM_CH-1:0] ch_out,
  output logic              frame_valid,
  output logic              locked,
  output logic              sync_err,
  output logic [ERR_W-1:0]  err_cnt
);
  ctl_t              ctl;
  logic [NUM_CH-1:0] shadow;

  tdm_sync_fsm #(
    .NUM_CH     (NUM_CH),
    .MISS_LIMIT (MISS_LIMIT)
  ) u_fsm (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_sync (frame_sync),
    .ctl        (ctl),
    .locked     (locked)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow      <= '0;
      ch_out      <= '0;
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
      err_cnt     <= '0;
    end else begin
      frame_valid <= ctl.complete;
      sync_err    <= ctl.realign;
      if (ctl.realign) begin
        // Drop the partial frame; the current bit becomes slot 0.
        shadow    <= '0;
        shadow[0] <= serial_in;
        if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
      end else if (ctl.cap) begin
        for (int i = 0; i < NUM_CH; i++)
          if (ctl.idx == SLOT_W'(i)) shadow[i] <= serial_in;
      end
      // Last slot bit bypasses the shadow so ch_out lands 1 clk later.
      if (ctl.complete) ch_out <= {serial_in, shadow[NUM_CH-2:0]};
    end
  end
endmodule

// File: tb/tb_tdm_demux.sv
// tb_tdm_demux: directed + random bench for tdm_demux against a queue-based
// frame model. A 2-slot instance carries most tests; a 16-slot instance
// takes a walking-one pattern.
module tb_tdm_demux;
  localparam int NC = 2;
  localparam int ML = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic sin = 1'b0, fs = 1'b0;
  logic [NC-1:0] ch;
  logic fv, lk, se;
  logic [7:0] ec;
  logic s16 = 1'b0, f16 = 1'b0;
  logic [15:0] ch16;
  logic fv16, lk16, se16;
  logic [7:0] ec16;

  always #5 clk = ~clk;

  tdm_demux #(.NUM_CH(NC), .MISS_LIMIT(ML)) dut (
    .clk(clk), .rst_n(rst_n), .serial_in(sin), .frame_sync(fs),
    .ch_out(ch), .frame_valid(fv), .locked(lk), .sync_err(se), .err_cnt(ec));

  tdm_demux #(.NUM_CH(16), .MISS_LIMIT(ML)) dut16 (
    .clk(clk), .rst_n(rst_n), .serial_in(s16), .frame_sync(f16),
    .ch_out(ch16), .frame_valid(fv16), .locked(lk16), .sync_err(se16), .err_cnt(ec16));

  int checks = 0, passes = 0;

  // Frame model: q holds the bits gathered for the frame in progress;
  // an empty queue while locked means the next bit is a frame start.
  bit          m_lock;
  bit          q[$];
  int          misses;
  logic [NC-1:0] m_ch;
  bit          m_fv, m_se;
  int          m_errs;

  function automatic void model_reset();
    m_lock = 0; q.delete(); misses = 0; m_ch = '0;
    m_fv = 0; m_se = 0; m_errs = 0;
  endfunction

  function automatic void model_step(bit b, bit f);
    m_fv = 0; m_se = 0;
    if (!m_lock) begin
      if (f) begin m_lock = 1; q.delete(); q.push_back(b); misses = 0; end
    end else if (q.size() == 0) begin
      if (f) misses = 0; else misses++;
      if (misses >= ML) begin m_lock = 0; misses = 0; end
      else q.push_back(b);
    end else if (f) begin
      m_se = 1;
      if (m_errs < 255) m_errs++;
      q.delete(); q.push_back(b); misses = 0;
    end else begin
      q.push_back(b);
      if (q.size() == NC) begin
        for (int i = 0; i < NC; i++) m_ch[i] = q[i];
        m_fv = 1;
        q.delete();
      end
    end
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
  endtask

  task automatic check_all();
    chk("ch_out",      32'(ch), 32'(m_ch));
    chk("frame_valid", 32'(fv), 32'(m_fv));
    chk("locked",      32'(lk), 32'(m_lock));
    chk("sync_err",    32'(se), 32'(m_se));
    chk("err_cnt",     32'(ec), 32'(m_errs));
  endtask

  // One clk: drive at negedge, model the posedge, check at next negedge.
  task automatic cyc(bit b, bit f);
    sin = b; fs = f;
    @(posedge clk);
    model_step(b, f);
    @(negedge clk);
    check_all();
  endtask

  logic [1:0] e027 [4];

  initial begin
    e027[0] = 2'b00; e027[1] = 2'b10; e027[2] = 2'b01; e027[3] = 2'b11;
    model_reset();

    // Reset state
    #1 rst_n = 1'b0;
    #1 check_all();
    chk("rst_fv16", 32'(fv16), 32'd0);
    @(negedge clk) rst_n = 1'b1;

    // 16 slots, walking one; the 2-slot instance idles in HUNT
    for (int f = 0; f < 16; f++) begin
      for (int j = 0; j < 16; j++) begin
        s16 = (j == f); f16 = (j == 0);
        @(posedge clk); @(negedge clk);
        chk("fv16", 32'(fv16), 32'(j == 15));
        if (j == 15) chk("ch16", 32'(ch16), 32'(16'h0001 << f));
      end
    end
    chk("lk16", 32'(lk16), 32'd1);
    s16 = 1'b0; f16 = 1'b0;
    check_all();

    // Four aligned frames (d0,d1) = 00,01,10,11
    for (int f = 0; f < 4; f++) begin
      cyc(f[1], 1'b1);
      cyc(f[0], 1'b0);
      chk("frame_const", 32'(ch), 32'(e027[f]));
    end

    // Withhold sync for three frames: flywheel twice, then drop lock
    for (int f = 0; f < 3; f++) begin
      cyc(1'b1, 1'b0);
      cyc(f[0], 1'b0);
    end
    chk("miss_unlock", 32'(lk), 32'd0);
    cyc(1'b0, 1'b0);

    // Misaligned sync at slot 1, then a clean frame
    cyc(1'b1, 1'b1); cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b1);
    cyc(1'b1, 1'b1);
    chk("misalign_err", 32'(se), 32'd1);
    cyc(1'b1, 1'b0);
    chk("realign_frame", 32'(ch), 32'(2'b11));

    // Random traffic: mostly aligned syncs, occasional misses and strays
    for (int n = 0; n < 400; n++) begin
      bit f;
      if (!m_lock || q.size() == 0) f = ($urandom_range(0, 7) != 0);
      else f = ($urandom_range(0, 15) == 0);
      cyc(1'($urandom), f);
    end

    // Error counter saturation
    repeat (262) cyc(1'($urandom), 1'b1);
    chk("err_sat", 32'(ec), 32'd255);

    // Async reset mid-frame
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b1);
    #2 rst_n = 1'b0;
    model_reset();
    #1 check_all();
    @(negedge clk) rst_n = 1'b1;
    cyc(1'b1, 1'b0); cyc(1'b1, 1'b0); cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b1);
    cyc(1'b1, 1'b0);
    chk("post_rst_frame", 32'(ch), 32'(2'b10));
    cyc(1'b0, 1'b1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/tdm_demux.md
TDM_DEMUX -- requirements
Module: tdm_demux

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, number of time slots per frame; legal range 2..16.
REQ-002 SHALL have parameter MISS_LIMIT, default 3, number of consecutive missing frame_sync pulses that drops lock; legal range 1..15.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have port serial_in  input  1  time-multiplexed data line carrying one slot bit per clk cycle.
REQ-006 SHALL have port frame_sync  input  1  high in the cycle that carries the slot-0 bit.
REQ-007 SHALL have port ch_out  output  NUM_CH  demultiplexed channel bits; bit k holds slot k of the last complete frame.
REQ-008 SHALL have port frame_valid  output  1  one-cycle pulse marking that ch_out was just updated.
REQ-009 SHALL have port locked  output  1  high while the FSM is in LOCKED.
REQ-010 SHALL have port sync_err  output  1  one-cycle pulse on a misaligned frame_sync.
REQ-011 SHALL have port err_cnt  output  8  saturating count of sync_err events.

Function
REQ-012 SHALL implement a two-state FSM: HUNT and LOCKED.
REQ-013 In HUNT, frame_sync=1 SHALL capture serial_in as shadow slot 0, set slot counter to 1 and move to LOCKED; frame_sync=0 SHALL capture nothing.
REQ-014 In LOCKED, each cycle SHALL capture serial_in into shadow[slot] and advance slot, wrapping NUM_CH-1 -> 0.
REQ-015 At slot NUM_CH-1, the edge SHALL load ch_out with the shadow bits plus the current serial_in and assert frame_valid the following cycle for exactly one cycle; latency is 1 clk from the last slot bit.
REQ-016 ch_out SHALL hold its value between frame_valid pulses and while in HUNT.
REQ-017 In LOCKED at slot 0 with frame_sync=1: miss counter cleared, sampling continues.
REQ-018 In LOCKED at slot 0 with frame_sync=0: miss counter increments and the slot is still sampled (flywheel).
REQ-019 When the miss counter reaches MISS_LIMIT: next state HUNT, partial frame discarded, no frame_valid for that frame.
REQ-020 frame_sync=1 in LOCKED at slot != 0: sync_err pulse next cycle, err_cnt +1 (saturates at 255), partial frame discarded, bit taken as slot 0, slot set to 1, miss counter cleared, state stays LOCKED.
REQ-021 A misaligned sync at slot NUM_CH-1 SHALL NOT produce frame_valid; realignment takes priority over frame completion.
REQ-022 locked SHALL be a registered reflection of the state, with no combinational path from inputs.

Reset
REQ-023 rst_n=0 SHALL immediately force: state HUNT, slot 0, miss counter 0, shadow 0, ch_out 0, frame_valid 0, locked 0, sync_err 0, err_cnt 0.
REQ-024 Reset asserted mid-frame SHALL discard the partial frame, and no frame_valid SHALL follow reset release until a new sync plus a full frame.

Structure
REQ-025 Package tdm_pkg SHALL hold the state enum (HUNT, LOCKED), the err_cnt width constant (8) and the default NUM_CH and MISS_LIMIT values.
REQ-026 The FSM, slot counter and miss counter SHALL live in sub-module tdm_sync_fsm; tdm_demux holds the shadow and output registers.

Verification
REQ-027 NUM_CH=2, sync on each slot 0, frames (d0,d1) = 00, 01, 10, 11 -> ch_out = 2'b00, 2'b10, 2'b01, 2'b11 with one frame_valid per frame, 1 clk after slot 1.
REQ-028 Lock, then withhold frame_sync for 3 frames (MISS_LIMIT=3) -> frames 1-2 still output (flywheel); at the 3rd missing sync locked=0, no frame_valid, ch_out holds.
REQ-029 frame_sync asserted at slot 1 while LOCKED -> sync_err pulse, err_cnt=1, no frame_valid for the broken frame, next full frame decoded correctly.
REQ-030 260 misaligned syncs -> err_cnt saturates at 255.
REQ-031 rst_n pulled low mid-frame asynchronously -> all outputs 0 before the next clk edge; after release, no frame_valid until sync plus 2 slots.
REQ-032 NUM_CH=16, walking-one pattern -> ch_out = 16'h0001, 16'h0002, ... on successive frames.
